// File: rtl/tx_rr_arbiter_pkg.sv
// Switch-wide definitions for the tx round-robin arbiter.
// Packet layout, arbiter state encoding and pointer helper.
package tx_rr_arbiter_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 8;
  localparam int PW        = $clog2(NUM_PORTS);

  typedef struct packed {
    logic [PW-1:0]     source;
    logic [PW-1:0]     target;
    logic [DATA_W-1:0] data;
  } packet_t;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  // Round-robin successor; wraps from NUM_PORTS-1 to 0.
  function automatic logic [PW-1:0] next_ptr(
    input logic [PW-1:0] i
  );
    if (int'(i) == NUM_PORTS - 1)
      return '0;
    return i + 1'b1;
  endfunction

endpackage

// File: rtl/tx_rr_arbiter_if.sv
// Rx-side request/grant bus and tx-side valid/ready output bus.
// master = arbiter, slave = rx ports plus downstream sink.
interface tx_rr_arbiter_if
  import tx_rr_arbiter_pkg::*;
  ();

  packet_t              rx_pkts [NUM_PORTS];
  logic [NUM_PORTS-1:0] rx_valids;
  logic [NUM_PORTS-1:0] grants;
  logic                 tx_ready;
  logic                 valid_out;
  packet_t              pkt_out;

  modport master (
    input  rx_pkts,
    input  rx_valids,
    output grants,
    input  tx_ready,
    output valid_out,
    output pkt_out
  );

  modport slave (
    output rx_pkts,
    output rx_valids,
    input  grants,
    output tx_ready,
    input  valid_out,
    input  pkt_out
  );

endinterface

// File: rtl/tx_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set req at or after ptr.
// In: req, ptr. Out: onehot winner, its idx, any request.
module rr_pick
  import tx_rr_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] onehot,
  output logic [PW-1:0]        idx,
  output logic                 any
);

  always_comb begin : pick
    int   j;
    logic found;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = (int'(ptr) + k) % NUM_PORTS;
      if (!found && req[j]) begin
        found     = 1'b1;
        idx       = PW'(j);
        onehot[j] = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/tx_rr_arbiter.sv
// Per-tx-port round-robin scheduler with one output stage.
// Ports: clk, rst, bus (rx req/grant + tx valid/ready), clr_stats, grant_cnt, stall_err.
module tx_rr_arbiter
  import tx_rr_arbiter_pkg::*;
#(
  parameter int PORT_ID   = 0,
  parameter int CNT_W     = 16,
  parameter int STALL_MAX = 255
) (
  input  logic                clk,
  input  logic                rst,
  tx_rr_arbiter_if.master     bus,
  input  logic                clr_stats,
  output logic [CNT_W-1:0]    grant_cnt [NUM_PORTS],
  output logic                stall_err
);

  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SW-1:0]    S_MAX   = SW'(STALL_MAX);
  localparam logic [SW-1:0]    S_PRE   = SW'(STALL_MAX - 1);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] onehot;
  logic [PW-1:0]        idx;
  logic [PW-1:0]        rr_ptr;
  logic                 any;
  logic                 load;
  logic                 stalled;
  logic                 hit;
  logic [SW-1:0]        stall_cnt;
  logic [SW-1:0]        stall_nxt;
  arb_state_t           state;

  always_comb begin
    req = '0;
    for (int j = 0; j < NUM_PORTS; j++)
      req[j] = bus.rx_valids[j] &&
               (bus.rx_pkts[j].target == PW'(PORT_ID));
  end

  rr_pick u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (onehot),
    .idx    (idx),
    .any    (any)
  );

  assign load = any && (!bus.valid_out || bus.tx_ready);

  // Gate on rst so no rx port drops a packet during reset.
  assign bus.grants = (load && !rst) ? onehot : '0;

  // BUSY tracks valid_out; a stall is BUSY with no ready.
  assign stalled   = (state == BUSY) && !bus.tx_ready;
  assign stall_nxt = !stalled            ? '0 :
                     (stall_cnt == S_MAX) ? stall_cnt :
                                           stall_cnt + 1'b1;
  // Fires only on the cycle the threshold is reached.
  assign hit = stalled && (stall_cnt == S_PRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.valid_out <= 1'b0;
      bus.pkt_out   <= '0;
      rr_ptr        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            state         <= BUSY;
            bus.valid_out <= 1'b1;
            bus.pkt_out   <= bus.rx_pkts[idx];
            rr_ptr        <= next_ptr(idx);
          end
        end
        BUSY: begin
          if (load) begin
            bus.valid_out <= 1'b1;
            bus.pkt_out   <= bus.rx_pkts[idx];
            rr_ptr        <= next_ptr(idx);
          end else if (bus.tx_ready) begin
            state         <= IDLE;
            bus.valid_out <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.valid_out <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_PORTS; j++)
        grant_cnt[j] <= '0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        // Clear first, then count this cycle's grant.
        if (clr_stats)
          grant_cnt[j] <= (load && onehot[j]) ?
                          CNT_W'(1) : '0;
        else if (load && onehot[j] &&
                 grant_cnt[j] != CNT_MAX)
          grant_cnt[j] <= grant_cnt[j] + CNT_W'(1);
      end
      stall_cnt <= stall_nxt;
      if (hit)
        stall_err <= 1'b1;
      else if (clr_stats)
        stall_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Bench for tx_rr_arbiter: rule-level model compared every cycle
// plus directed scenarios with literal expectations.
module tb_tx_rr_arbiter;
  import tx_rr_arbiter_pkg::*;

  localparam int PID  = 2;
  localparam int CW   = 2;
  localparam int SMAX = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          clr_stats;
  logic [CW-1:0] grant_cnt [NUM_PORTS];
  logic          stall_err;

  int n_cmp;
  int n_bad;

  tx_rr_arbiter_if bus ();

  tx_rr_arbiter #(
    .PORT_ID   (PID),
    .CNT_W     (CW),
    .STALL_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_stats (clr_stats),
    .grant_cnt (grant_cnt),
    .stall_err (stall_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: state as plain ints.
  int      m_ptr;
  bit      m_valid;
  packet_t m_pkt;
  int      m_cnt [NUM_PORTS];
  int      m_run;
  bit      m_err;

  function automatic bit m_req(int j);
    return bus.rx_valids[j] && (int'(bus.rx_pkts[j].target) == PID);
  endfunction

  always @(negedge clk) begin : model
    int w;
    int eg;
    bit blocked;
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_pkt = '0;
      m_run = 0; m_err = 0;
      for (int j = 0; j < NUM_PORTS; j++) m_cnt[j] = 0;
      check("m_rst_grants", 32'(bus.grants), 0);
      check("m_rst_valid", 32'(bus.valid_out), 0);
    end else begin
      blocked = m_valid && !bus.tx_ready;
      w = -1;
      if (!blocked)
        for (int k = 0; k < NUM_PORTS; k++)
          if (w < 0 && m_req((m_ptr + k) % NUM_PORTS))
            w = (m_ptr + k) % NUM_PORTS;
      eg = (w >= 0) ? (1 << w) : 0;
      check("m_grants", 32'(bus.grants), 32'(eg));
      check("m_valid", 32'(bus.valid_out), 32'(m_valid));
      if (m_valid)
        check("m_pkt", 32'(bus.pkt_out), 32'(m_pkt));
      for (int j = 0; j < NUM_PORTS; j++)
        check("m_cnt", 32'(grant_cnt[j]), 32'(m_cnt[j]));
      check("m_err", 32'(stall_err), 32'(m_err));
      if (blocked) m_run++;
      else m_run = 0;
      if (blocked && m_run == SMAX) m_err = 1;
      else if (clr_stats) m_err = 0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (clr_stats) m_cnt[j] = 0;
        if (j == w && m_cnt[j] < CMAX) m_cnt[j]++;
      end
      if (w >= 0) begin
        m_pkt = bus.rx_pkts[w];
        m_valid = 1;
        m_ptr = (w + 1) % NUM_PORTS;
      end else if (!blocked) begin
        m_valid = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rx(int j, bit v, logic [1:0] t, logic [7:0] d);
    bus.rx_valids[j] = v;
    bus.rx_pkts[j] = '{source: 2'(j), target: t, data: d};
  endtask

  task automatic clr_rx();
    for (int j = 0; j < NUM_PORTS; j++) set_rx(j, 0, 0, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    clr_stats = 1'b0;
    bus.tx_ready = 1'b1;
    clr_rx();
    tick();
    check("rst_valid", 32'(bus.valid_out), 0);
    check("rst_pkt", 32'(bus.pkt_out), 0);
    check("rst_cnt0", 32'(grant_cnt[0]), 0);
    check("rst_err", 32'(stall_err), 0);
    tick();
    rst = 1'b0;

    // Single source
    set_rx(1, 1, 2, 8'hA5);
    #1 check("single_grant", 32'(bus.grants), 32'h2);
    tick();
    set_rx(1, 0, 2, 8'hA5);
    check("single_valid", 32'(bus.valid_out), 1);
    check("single_data", 32'(bus.pkt_out.data), 32'hA5);
    check("single_cnt1", 32'(grant_cnt[1]), 1);
    tick();
    check("single_drain", 32'(bus.valid_out), 0);

    // Foreign target ignored
    set_rx(0, 1, 1, 8'h77);
    #1 check("foreign_grant", 32'(bus.grants), 0);
    tick();
    check("foreign_valid", 32'(bus.valid_out), 0);
    clr_rx();

    // Restart at rr_ptr=0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Fairness
    for (int j = 0; j < NUM_PORTS; j++) set_rx(j, 1, 2, 8'(8'h10 + j));
    for (int c = 0; c < 8; c++) begin
      #1 check("fair_grant", 32'(bus.grants), 32'(1 << (c % 4)));
      tick();
    end
    for (int j = 0; j < NUM_PORTS; j++)
      check("fair_cnt", 32'(grant_cnt[j]), 2);
    check("fair_last", 32'(bus.pkt_out.data), 32'h13);

    // Backpressure
    set_rx(1, 0, 2, 0);
    set_rx(2, 0, 2, 0);
    bus.tx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_grant", 32'(bus.grants), 0);
      check("bp_hold", 32'(bus.pkt_out.data), 32'h13);
      tick();
    end
    bus.tx_ready = 1'b1;
    #1 check("bp_resume", 32'(bus.grants), 32'h1);
    tick();
    check("bp_data0", 32'(bus.pkt_out.data), 32'h10);
    #1 check("bp_next", 32'(bus.grants), 32'h8);
    tick();
    clr_rx();
    check("bp_noerr", 32'(stall_err), 0);

    // Watchdog
    bus.tx_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("wd_err", 32'(stall_err), 32'(c >= SMAX));
    end
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("wd_clr", 32'(stall_err), 0);
    check("wd_cnt0", 32'(grant_cnt[0]), 0);
    bus.tx_ready = 1'b1;
    tick();

    // Saturation
    set_rx(2, 1, 2, 8'h22);
    for (int c = 0; c < 5; c++) begin
      #1 check("sat_grant", 32'(bus.grants), 32'h4);
      tick();
    end
    check("sat_cnt2", 32'(grant_cnt[2]), 3);
    clr_stats = 1'b1;
    #1 check("sat_clr_grant", 32'(bus.grants), 32'h4);
    tick();
    clr_stats = 1'b0;
    check("sat_clr_cnt2", 32'(grant_cnt[2]), 1);

    // Threshold beats clear
    clr_rx();
    bus.tx_ready = 1'b0;
    repeat (3) tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("thr_err", 32'(stall_err), 1);
    check("thr_cnt2", 32'(grant_cnt[2]), 0);

    // Reset mid-operation
    set_rx(0, 1, 2, 8'h30);
    set_rx(1, 1, 2, 8'h31);
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    #1 check("mid_valid", 32'(bus.valid_out), 0);
    check("mid_grant", 32'(bus.grants), 0);
    check("mid_err", 32'(stall_err), 0);
    tick();
    rst = 1'b0;
    #1 check("mid_first", 32'(bus.grants), 32'h1);
    tick();
    check("mid_data", 32'(bus.pkt_out.data), 32'h30);
    #1 check("mid_second", 32'(bus.grants), 32'h2);
    tick();
    clr_rx();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
